pc_redirect_ctrl: RTL and testbench

Sequences the 10-bit fetch PC for the RISC-V core and is the sole controller of the shared add_imm adder (pc_d + imm_add -> pc_imm). Each cycle it chooses sequential, branch-target (through add_imm) or JALR next-PC. It applies hazard stalls, generates the pipeline flush bubble on redirects, and traps misaligned or out-of-range targets. It sits between decode/hazard logic and instruction memory.

---
 rtl/pc_redirect_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer and sole owner of the shared add_imm adder.
// Selects sequential, branch or JALR next-PC; inserts flush bubbles and traps bad targets.
module pc_redirect_ctrl #(
  parameter int unsigned     PC_W         = 10,
  parameter logic [PC_W-1:0] RESET_PC     = {PC_W{1'b0}},
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_pc_i,
  input  logic [31:0]     imm_i,
  input  logic            jalr_valid_i,
  input  logic [31:0]     jalr_target_i,
  output logic [PC_W-1:0] pc_d_o,
  output logic [31:0]     imm_add_o,
  input  logic [31:0]     pc_imm_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic            halted_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_STEP    = {{(PC_W-3){1'b0}}, 3'd4};

  state_e            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              flush_q, flush_d;
  logic              misalign_q, misalign_d;
  logic              halted_q, halted_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;

  logic              redirect_s;
  logic [31:0]       target_s;
  logic              target_ok_s;
  logic [31:0]       jalr_tgt_s;

  // A target must be word aligned and fit inside the fetch address space.
  function automatic logic target_legal(input logic [31:0] t);
    logic upper_zero;
    upper_zero = (t >> PC_W) == 32'd0;
    return (t[1:0] == 2'b00) && upper_zero;
  endfunction

  assign pc_d_o    = br_pc_i;
  assign imm_add_o = imm_i;

  // Redirect selection: JALR outranks a taken branch.
  always_comb begin
    jalr_tgt_s = jalr_target_i & 32'hFFFF_FFFE;
    if (jalr_valid_i) begin
      redirect_s = 1'b1;
      target_s   = jalr_tgt_s;
    end else if (br_valid_i && br_taken_i) begin
      redirect_s = 1'b1;
      target_s   = pc_imm_i;
    end else begin
      redirect_s = 1'b0;
      target_s   = 32'd0;
    end
    target_ok_s = target_legal(target_s);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      halted_q      <= 1'b0;
      flush_cnt_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      halted_q      <= halted_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_s) begin
          state_d = target_ok_s ? ST_FLUSH : ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  // Next values of the PC, counter and status outputs.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    halted_d      = halted_q;
    flush_cnt_d   = flush_cnt_q;
    case (state_q)
      ST_BOOT: begin
        fetch_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (redirect_s && target_ok_s) begin
          fetch_pc_d    = target_s[PC_W-1:0];
          fetch_valid_d = 1'b0;
          flush_d       = 1'b1;
          flush_cnt_d   = FLUSH_INIT;
        end else if (redirect_s) begin
          // Bad target: keep the last fetched PC for the trap handler.
          fetch_valid_d = 1'b0;
          flush_d       = 1'b1;
          misalign_d    = 1'b1;
          halted_d      = 1'b1;
        end else if (stall_i) begin
          fetch_valid_d = 1'b1;
        end else begin
          fetch_pc_d    = fetch_pc_q + PC_STEP;
          fetch_valid_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 3'd0) begin
          fetch_valid_d = 1'b1;
        end else begin
          flush_cnt_d   = flush_cnt_q - 3'd1;
          flush_d       = 1'b1;
          fetch_valid_d = 1'b0;
        end
      end
      ST_HALT: begin
        fetch_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
        fetch_pc_d    = RESET_PC;
        fetch_valid_d = 1'b0;
        halted_d      = 1'b0;
        flush_cnt_d   = 3'd0;
      end
    endcase
  end

  assign pc_o          = fetch_pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign flush_o       = flush_q;
  assign misalign_o    = misalign_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed plus randomized bench for pc_redirect_ctrl against a behavioural fetch model.
module tb_pc_redirect_ctrl;

  localparam int FLUSH_N = 2;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        br_valid_i;
  logic        br_taken_i;
  logic [9:0]  br_pc_i;
  logic [31:0] imm_i;
  logic        jalr_valid_i;
  logic [31:0] jalr_target_i;
  logic [9:0]  pc_d_o;
  logic [31:0] imm_add_o;
  logic [31:0] pc_imm_i;
  logic [9:0]  pc_o;
  logic        fetch_valid_o;
  logic        flush_o;
  logic        misalign_o;
  logic        halted_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: what the fetch unit should be showing right now.
  int m_pc;
  bit m_fv, m_flush, m_mis, m_halt, m_boot;
  int m_bubbles_left;

  pc_redirect_ctrl #(.PC_W(10), .RESET_PC(10'd0), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .br_valid_i    (br_valid_i),
    .br_taken_i    (br_taken_i),
    .br_pc_i       (br_pc_i),
    .imm_i         (imm_i),
    .jalr_valid_i  (jalr_valid_i),
    .jalr_target_i (jalr_target_i),
    .pc_d_o        (pc_d_o),
    .imm_add_o     (imm_add_o),
    .pc_imm_i      (pc_imm_i),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o),
    .halted_o      (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("pc_o", {22'd0, pc_o}, 32'(m_pc));
    chk("fetch_valid_o", {31'd0, fetch_valid_o}, {31'd0, m_fv});
    chk("flush_o", {31'd0, flush_o}, {31'd0, m_flush});
    chk("misalign_o", {31'd0, misalign_o}, {31'd0, m_mis});
    chk("halted_o", {31'd0, halted_o}, {31'd0, m_halt});
  endtask

  task automatic model_reset();
    m_pc = 0; m_fv = 1'b0; m_flush = 1'b0; m_mis = 1'b0; m_halt = 1'b0;
    m_boot = 1'b1; m_bubbles_left = 0;
  endtask

  // One clock edge of the fetch unit, using the inputs currently driven.
  task automatic model_edge();
    longint unsigned tgt;
    bit redir;
    m_mis = 1'b0;
    if (m_halt) begin
      m_flush = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_fv   = 1'b1;
    end else if (m_bubbles_left > 0) begin
      m_bubbles_left--;
      if (m_bubbles_left == 0) begin
        m_flush = 1'b0;
        m_fv    = 1'b1;
      end
    end else begin
      redir = jalr_valid_i || (br_valid_i && br_taken_i);
      if (jalr_valid_i) tgt = longint'(jalr_target_i) / 2 * 2;
      else              tgt = (longint'(br_pc_i) + longint'(imm_i)) % 64'h1_0000_0000;
      if (redir && (tgt % 4 == 0) && (tgt < 1024)) begin
        m_pc = int'(tgt);
        m_bubbles_left = FLUSH_N;
        m_flush = 1'b1;
        m_fv    = 1'b0;
      end else if (redir) begin
        m_mis   = 1'b1;
        m_flush = 1'b1;
        m_fv    = 1'b0;
        m_halt  = 1'b1;
      end else if (!stall_i) begin
        m_pc = (m_pc + 4) % 1024;
      end
    end
  endtask

  task automatic drive(input bit st, input bit bv, input bit bt, input logic [9:0] bpc,
                       input logic [31:0] im, input bit jv, input logic [31:0] jt);
    stall_i = st; br_valid_i = bv; br_taken_i = bt; br_pc_i = bpc; imm_i = im;
    jalr_valid_i = jv; jalr_target_i = jt;
    pc_imm_i = {22'd0, bpc} + im;
    #1;
    chk("pc_d_o", {22'd0, pc_d_o}, {22'd0, bpc});
    chk("imm_add_o", imm_add_o, im);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    @(negedge clk);
    check_outs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_outs();
    rst_n = 1'b1;

    // Boot and sequential fetch
    repeat (4) step();
    chk("seq_pc", {22'd0, pc_o}, 32'd12);

    // Taken branch 4+8 -> 12 with a two-cycle bubble
    drive(1'b0, 1'b1, 1'b1, 10'd4, 32'd8, 1'b0, 32'd0);
    step();
    chk("br_flush", {31'd0, flush_o}, 32'd1);
    idle();
    repeat (3) step();
    chk("br_after", {22'd0, pc_o}, 32'd16);

    // JALR beats taken branch and stall; bit0 of target cleared
    drive(1'b1, 1'b1, 1'b1, 10'd8, 32'd32, 1'b1, 32'd101);
    step();
    idle();
    repeat (2) step();
    chk("jalr_pc", {22'd0, pc_o}, 32'd100);

    // Stall holds PC at 20
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 32'd20);
    step();
    idle();
    repeat (2) step();
    drive(1'b1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0);
    repeat (3) step();
    chk("stall_pc", {22'd0, pc_o}, 32'd20);
    idle();
    step();
    chk("stall_release", {22'd0, pc_o}, 32'd24);

    // Wrap from 1020 to 0
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 32'd1020);
    step();
    idle();
    repeat (3) step();
    chk("wrap_pc", {22'd0, pc_o}, 32'd0);

    // Misaligned branch target 7 traps and halts
    drive(1'b0, 1'b1, 1'b1, 10'd4, 32'd3, 1'b0, 32'd0);
    step();
    chk("trap_mis", {31'd0, misalign_o}, 32'd1);
    idle();
    repeat (3) step();
    chk("halt_hold", {31'd0, halted_o}, 32'd1);
    do_reset();

    // Reset during flush, then out-of-range JALR
    step();
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 32'd200);
    step();
    do_reset();
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    idle();
    step();
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 32'd2048);
    step();
    chk("range_mis", {31'd0, misalign_o}, 32'd1);
    idle();
    step();
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit st, bv, bt, jv;
      logic [9:0] bpc;
      logic [31:0] im, jt;
      int offs;
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end
      st  = ($urandom_range(0, 99) < 30);
      bv  = ($urandom_range(0, 99) < 25);
      bt  = ($urandom_range(0, 1) == 1);
      bpc = 10'($urandom_range(0, 255) * 4);
      offs = int'($urandom_range(0, 255)) - 128;
      im  = 32'(offs * 4);
      if ($urandom_range(0, 9) == 0) im = im + 32'($urandom_range(1, 3));
      jv  = ($urandom_range(0, 99) < 8);
      jt  = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) jt = 32'($urandom_range(0, 4095));
      drive(st, bv, bt, bpc, im, jv, jt);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
